// File: rtl/dram_lsu.sv
// MEM-stage load/store initiator for a word-wide DRAM with one-edge read latency.
// Sub-word stores are read-modify-write; loads are lane-selected and sign/zero-extended.
module dram_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sext_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic [DATA_WIDTH-1:0] BYTE_MASK = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
    localparam logic [DATA_WIDTH-1:0] HALF_MASK = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_ERR} state_t;

    state_t                state_q,     state_d;
    logic                  ready_q,     ready_d;
    logic                  done_q,      done_d;
    logic                  err_q,       err_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_cs_q,    mem_cs_d;
    logic                  mem_we_q,    mem_we_d;

    // Latched request; the word address itself lives in mem_addr_q.
    logic [1:0]            off_q,   off_d;
    logic [1:0]            size_q,  size_d;
    logic                  sext_q,  sext_d;
    logic                  store_q, store_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  illegal_req;
    logic [1:0]            lane;
    logic [4:0]            shift;
    logic [DATA_WIDTH-1:0] lane_word;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;

    // Datapath: lane position, extracted load value and RMW merge word.
    always_comb begin
        illegal_req = (size_i == SZ_BAD)
                   || (size_i == SZ_HALF && addr_i[0])
                   || (size_i == SZ_WORD && addr_i[1:0] != 2'b00);

        lane = off_q;
        if (BIG_ENDIAN) begin
            case (size_q)
                SZ_BYTE: lane = 2'd3 - off_q;
                SZ_HALF: lane = 2'd2 - off_q;
                default: lane = 2'd0;
            endcase
        end
        shift = {lane, 3'b000};

        lane_word = mem_rdata_i >> shift;
        case (size_q)
            SZ_BYTE: load_ext = {{(DATA_WIDTH-8){sext_q & lane_word[7]}}, lane_word[7:0]};
            SZ_HALF: load_ext = {{(DATA_WIDTH-16){sext_q & lane_word[15]}}, lane_word[15:0]};
            default: load_ext = lane_word;
        endcase

        lane_mask = ((size_q == SZ_BYTE) ? BYTE_MASK : HALF_MASK) << shift;
        merged    = (mem_rdata_i & ~lane_mask) | ((wdata_q << shift) & lane_mask);
    end

    // NOTE: every _d gets a hold/default value before the case, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        off_d       = off_q;
        size_d      = size_q;
        sext_d      = sext_q;
        store_d     = store_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    off_d   = addr_i[1:0];
                    size_d  = size_i;
                    sext_d  = sext_i;
                    store_d = we_i;
                    wdata_d = wdata_i;
                    if (illegal_req) begin
                        state_d = S_ERR;
                    end else if (we_i && size_i == SZ_WORD) begin
                        state_d     = S_WR;
                        mem_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = wdata_i;
                        mem_we_d    = 1'b1;
                    end else begin
                        state_d    = S_RD;
                        mem_addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_cs_d   = 1'b1;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                mem_cs_d = 1'b0;
                if (store_q) begin
                    state_d     = S_WR;
                    mem_wdata_d = merged;
                    mem_we_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    rdata_d = load_ext;
                    done_d  = 1'b1;
                end
            end
            S_WR: begin
                state_d  = S_IDLE;
                mem_we_d = 1'b0;
                done_d   = 1'b1;
            end
            S_ERR: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            store_q     <= store_d;
            wdata_q     <= wdata_d;
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_cs_o    = mem_cs_q;
    assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_dram_lsu.sv
// Self-checking bench for dram_lsu: directed vector table, randomized requests against a
// byte-level memory model, and hand sequences for busy-drop, back-to-back and mid-RMW reset.
module tb_dram_lsu;

    localparam bit BE = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, sext_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        ready_o, done_o, err_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_cs_o, mem_we_o;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    dram_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BIG_ENDIAN(BE)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .we_i(we_i), .size_i(size_i), .sext_i(sext_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // DRAM: registered read, garbage on the bus whenever no read was sampled.
    logic [31:0] dram [0:63];
    always @(posedge clk) begin
        if (mem_we_o) dram[mem_addr_o[7:2]] <= mem_wdata_o;
        mem_rdata_i <= mem_cs_o ? dram[mem_addr_o[7:2]] : $urandom();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed view) ----------------
    function automatic logic [7:0] get_byte(input logic [31:0] w, input int k);
        return BE ? w[8*(3-k) +: 8] : w[8*k +: 8];
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] w, input int k, input logic [7:0] b);
        logic [31:0] r = w;
        if (BE) r[8*(3-k) +: 8] = b;
        else    r[8*k +: 8]     = b;
        return r;
    endfunction

    function automatic bit m_illegal(input logic [1:0] size, input int off);
        return size == 2'd3 || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
    endfunction

    function automatic int m_latency(input logic we, input logic [1:0] size, input int off);
        if (m_illegal(size, off)) return 1;
        if (we) return (size == 2'd2) ? 1 : 3;
        return 2;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic sext, input int off);
        logic [7:0] hi, lo;
        int val;
        if (size == 2'd0) begin
            val = get_byte(w, off);
            if (sext && val >= 128) val -= 256;
            return 32'(val);
        end
        if (size == 2'd1) begin
            hi  = BE ? get_byte(w, off)     : get_byte(w, off + 1);
            lo  = BE ? get_byte(w, off + 1) : get_byte(w, off);
            val = hi * 256 + lo;
            if (sext && val >= 32768) val -= 65536;
            return 32'(val);
        end
        return BE ? {get_byte(w, 0), get_byte(w, 1), get_byte(w, 2), get_byte(w, 3)}
                  : {get_byte(w, 3), get_byte(w, 2), get_byte(w, 1), get_byte(w, 0)};
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] size,
                                            input int off, input logic [31:0] d);
        logic [31:0] r = w;
        if (size == 2'd0) return set_byte(r, off, d[7:0]);
        if (size == 2'd1) begin
            r = set_byte(r, BE ? off : off + 1, d[15:8]);
            return set_byte(r, BE ? off + 1 : off, d[7:0]);
        end
        return d;
    endfunction

    // Issue one request from a point away from the clock edge; E0 is the next rising edge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic acc);
        check("ready_before_req", {31'b0, ready_o}, 32'd1);
        req_i = 1'b1; we_i = we; size_i = size; sext_i = sext; addr_i = addr; wdata_i = wdata;
        @(posedge clk); #1;
        req_i = 1'b0;
        lat = 0; err = 1'b0;
        acc = mem_cs_o | mem_we_o;
        while (lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (done_o) begin
                err = err_o;
                break;
            end
            acc |= mem_cs_o | mem_we_o;
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          lat;
        logic        err, acc;
        logic [31:0] exp_rd;

        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; sext_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        for (int i = 0; i < 64; i++) dram[i] = 32'h0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'b0, ready_o},  32'd1);
        check("rst_done",   {31'b0, done_o},   32'd0);
        check("rst_err",    {31'b0, err_o},    32'd0);
        check("rst_rdata",  rdata_o,           32'd0);
        check("rst_maddr",  mem_addr_o,        32'd0);
        check("rst_mwdata", mem_wdata_o,       32'd0);
        check("rst_cs",     {31'b0, mem_cs_o}, 32'd0);
        check("rst_we",     {31'b0, mem_we_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- directed vector table ----------------
        //              we    sz    sx    addr    wdata         init          lat err rdata         mem
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h80FF7F01, 2, 0, 32'hFFFFFF80, 32'h80FF7F01});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h80FF7F01, 2, 0, 32'h00000080, 32'h80FF7F01});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD,     32'h11223344, 3, 0, 32'h00000080, 32'hABCD3344});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        32'h01020304, 1, 1, 32'h00000080, 32'h01020304});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h08, 32'h0,        32'h05060708, 1, 1, 32'h00000080, 32'h05060708});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h80FF7F01, 2, 0, 32'hFFFF80FF, 32'h80FF7F01});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h80FF7F01, 2, 0, 32'h00007F01, 32'h80FF7F01});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h41, 32'hFFFF55,   32'h11223344, 3, 0, 32'h00007F01, 32'h11225544});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 32'h00000000, 1, 0, 32'h00007F01, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h11, 32'h1234,     32'h99887766, 1, 1, 32'h00007F01, 32'h99887766});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h80FF7F01, 2, 0, 32'h0000007F, 32'h80FF7F01});

        foreach (vecs[i]) begin
            dram[vecs[i].addr[7:2]] = vecs[i].init;
            do_req(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, lat, err, acc);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_access", i), {31'b0, acc}, {31'b0, ~vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
            check($sformatf("vec%0d_mem", i), dram[vecs[i].addr[7:2]], vecs[i].exp_mem);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), {31'b0, done_o}, 32'd0);
        end

        // ---------------- randomized requests vs model ----------------
        exp_rd = 32'h0000007F;
        for (int n = 0; n < 200; n++) begin
            logic        r_we, r_sx;
            logic [1:0]  r_sz;
            logic [31:0] r_addr, r_wd, r_init, exp_mem;
            int          off;
            bit          ill;
            r_we   = 1'($urandom_range(0, 1));
            r_sx   = 1'($urandom_range(0, 1));
            r_sz   = 2'($urandom_range(0, 3));
            off    = $urandom_range(0, 3);
            r_addr = 32'($urandom_range(0, 63) * 4 + off);
            r_wd   = $urandom();
            r_init = $urandom();
            ill    = m_illegal(r_sz, off);
            dram[r_addr[7:2]] = r_init;
            exp_mem = (ill || !r_we) ? r_init : m_store(r_init, r_sz, off, r_wd);
            if (!ill && !r_we) exp_rd = m_load(r_init, r_sz, r_sx, off);
            do_req(r_we, r_sz, r_sx, r_addr, r_wd, lat, err, acc);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(m_latency(r_we, r_sz, off)));
            check($sformatf("rnd%0d_err", n), {31'b0, err}, {31'b0, ill});
            check($sformatf("rnd%0d_rdata", n), rdata_o, exp_rd);
            check($sformatf("rnd%0d_mem", n), dram[r_addr[7:2]], exp_mem);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // ---------------- request while busy is dropped ----------------
        @(posedge clk); #1;
        dram[5] = 32'h0BADF00D;
        dram[6] = 32'h11111111;
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sext_i = 1'b0; addr_i = 32'h14; wdata_i = 32'h0;
        @(posedge clk); #1;
        we_i = 1'b1; addr_i = 32'h18; wdata_i = 32'hFFFFFFFF;
        check("busy_ready_low", {31'b0, ready_o}, 32'd0);
        @(posedge clk); #1;
        req_i = 1'b0;
        check("busy_no_done_e1", {31'b0, done_o}, 32'd0);
        @(posedge clk); #1;
        check("busy_done_e2", {31'b0, done_o}, 32'd1);
        check("busy_rdata", rdata_o, 32'h0BADF00D);
        repeat (3) @(posedge clk);
        #1;
        check("busy_dropped_store", dram[6], 32'h11111111);
        check("busy_no_extra_done", {31'b0, done_o}, 32'd0);

        // ---------------- back-to-back sw then lw in the done cycle ----------------
        dram[0] = 32'h0;
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, lat, err, acc);
        check("b2b_sw_latency", 32'(lat), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, err, acc);
        check("b2b_lw_latency", 32'(lat), 32'd2);
        check("b2b_lw_rdata", rdata_o, 32'h12345678);

        // ---------------- reset in CAP of sb 0x55 to 0x40 ----------------
        @(posedge clk); #1;
        dram[16] = 32'hA1B2C3D4;
        req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; sext_i = 1'b0; addr_i = 32'h40; wdata_i = 32'h55;
        @(posedge clk); #1;
        req_i = 1'b0;
        check("rmw_cs_in_rd", {31'b0, mem_cs_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready",  {31'b0, ready_o},  32'd1);
        check("abort_done",   {31'b0, done_o},   32'd0);
        check("abort_err",    {31'b0, err_o},    32'd0);
        check("abort_rdata",  rdata_o,           32'd0);
        check("abort_maddr",  mem_addr_o,        32'd0);
        check("abort_mwdata", mem_wdata_o,       32'd0);
        check("abort_cs",     {31'b0, mem_cs_o}, 32'd0);
        check("abort_we",     {31'b0, mem_we_o}, 32'd0);
        acc = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            acc |= done_o | mem_we_o;
        end
        check("abort_no_done_or_write", {31'b0, acc}, 32'd0);
        check("abort_mem_unchanged", dram[16], 32'hA1B2C3D4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
